fixed_mul_pipe: RTL and testbench
=================================

Name: fixed_mul_pipe

Overview:
Parametrised, pipelined signed fixed-point multiplier. Format is Q(INT_BITS).(FRAC_BITS). Per-transaction modes select truncate or round, and wrap or saturate, and an overflow flag is reported. Operands and results use valid/ready handshakes with full backpressure, so the block drops into streaming datapaths (MAC/ALU lanes) in place of the combinational Q8.8 multiplier. With defaults and trunc/wrap mode, result bits are identical to the legacy Q8.8 product slice [23:8].

Parameters:
INT_BITS, 8, integer bits including sign
FRAC_BITS, 8, fractional bits (>=1)
STAGES, 2, pipeline register slots (>=1); equals latency in cycles with no stalls

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands valid
in_ready  out  1  block can accept operands this cycle
a  in  W=INT_BITS+FRAC_BITS  signed operand
b  in  W  signed operand
rnd_mode  in  1  0=truncate (floor), 1=round half up; sampled with operands
sat_en  in  1  0=wrap, 1=saturate; sampled with operands
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result  out  W  signed Q(INT_BITS).(FRAC_BITS) product
overflow  out  1  true product exceeded W-bit signed range (flag set in both wrap and sat modes)

Behaviour:
- Reset (async assert, sync-safe deassert handled by system): all slot valid bits=0, out_valid=0, result=0, overflow=0. A reset mid-operation discards every in-flight transaction, and no result is emitted for it.
- Input transfer: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready.
- Pipeline: STAGES slots, each with a valid bit, carrying data plus rnd_mode/sat_en.
  - Slot k loads from slot k-1 (slot 0 from the input) when slot k is empty or slot k advances that cycle.
  - The last slot advances when out_ready=1.
  - Bubbles collapse.
  - in_ready = !valid[0] || slot 0 advances. It is combinational from out_ready through the chain and must not depend on in_valid.
- Throughput: 1 transaction/cycle when out_ready is held high. Latency: exactly STAGES cycles from input transfer to out_valid when there is no stall.
- A stalled output holds result/overflow stable while out_valid=1 && out_ready=0. Transactions are never dropped, duplicated or reordered.
- Simultaneous input and output transfer on a full pipe is legal and keeps occupancy constant.
- Arithmetic (logic may be distributed over slots freely; the result must be exact):
  - P = a*b as a full 2W-bit signed product.
  - rnd_mode=0: S = P >>> FRAC_BITS (arithmetic shift, floor toward -inf).
  - rnd_mode=1: S = (P + 2^(FRAC_BITS-1)) >>> FRAC_BITS. Compute at 2W+1 bits so the add cannot wrap.
  - ovf = S not representable in W-bit signed (S > 2^(W-1)-1 or S < -2^(W-1)).
  - sat_en=0: result = S[W-1:0] (wrap).
  - sat_en=1 and ovf: result = max positive (0x7FFF at defaults) if S>0, else min negative (0x8000).
  - overflow = ovf in both modes.
- Outputs are registered from the last slot; there is no combinational path from a/b to result.

Test Plan:
1. Defaults, trunc/wrap: a=0x0180 (1.5), b=0x0200 (2.0) -> result 0x0300, overflow 0, out_valid exactly 2 cycles after accept.
2. Overflow modes: a=0x6400 (100), b=0x0200 -> wrap gives result 0xC800, overflow 1; sat gives 0x7FFF, overflow 1. Also a=0x8000, b=0xFF00 (-128*-1) with sat -> 0x7FFF, overflow 1.
3. Rounding: a=0x0001, b=0x0080 -> trunc 0x0000, round 0x0001. a=0xFFFF, b=0x0080 -> trunc 0xFFFF, round 0x0000. All with overflow 0.
4. Backpressure: stream 8 random operand pairs with in_valid=1 while out_ready toggles pseudo-randomly. Check:
   - results match the reference model in order, with none lost or duplicated;
   - in_ready=0 only when the pipe is full and out_ready=0;
   - result is stable during stalls.
5. Full-rate and parameter sweep: out_ready=1, back-to-back inputs -> one result per cycle. Repeat with STAGES=1 and STAGES=4, and with INT_BITS=4, FRAC_BITS=12, checking latency and values against the model.
6. Reset mid-flight: accept 2 transactions, assert rst_n=0 for 1 cycle -> out_valid=0, result=0, overflow=0 immediately (async). After release, neither in-flight result ever appears, and a new transaction completes normally.

Source files
------------

// File: rtl/fixed_mul_pipe.sv
// Pipelined signed fixed-point multiplier (Q INT_BITS.FRAC_BITS) with per-transaction
// truncate/round and wrap/saturate modes, overflow flag and valid/ready flow control.
module fixed_mul_pipe #(
    parameter int INT_BITS  = 8,
    parameter int FRAC_BITS = 8,
    parameter int STAGES    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [INT_BITS+FRAC_BITS-1:0] a,
    input  logic [INT_BITS+FRAC_BITS-1:0] b,
    input  logic                          rnd_mode,
    input  logic                          sat_en,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [INT_BITS+FRAC_BITS-1:0] result,
    output logic                          overflow
);
    localparam int W  = INT_BITS + FRAC_BITS;
    localparam int PW = 2 * W;
    localparam logic [PW:0]  HALF    = {{PW{1'b0}}, 1'b1} << (FRAC_BITS - 1);
    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MAX_NEG = {1'b1, {(W-1){1'b0}}};

    // Scale a full product back to W bits; one extra bit keeps the rounding add exact.
    function automatic logic [W:0] finalize(input logic signed [PW-1:0] p,
                                            input logic rnd, input logic sat);
        logic signed [PW:0] s;
        logic               ovf;
        logic [W-1:0]       r;
        s = {p[PW-1], p};
        if (rnd) s = s + $signed(HALF);
        s   = s >>> FRAC_BITS;
        ovf = !((&s[PW:W-1]) || !(|s[PW:W-1]));
        r   = s[W-1:0];
        if (sat && ovf) r = s[PW] ? MAX_NEG : MAX_POS;
        return {ovf, r};
    endfunction

    logic signed [PW-1:0] prod_in;
    assign prod_in = PW'($signed(a)) * PW'($signed(b));

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] load;

    // A slot may load when it is empty or its content moves on this cycle.
    always_comb begin
        load = '0;
        load[STAGES-1] = !vld_q[STAGES-1] || out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            load[k] = !vld_q[k] || load[k+1];
        end
    end

    assign in_ready  = load[0];
    assign out_valid = vld_q[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            if (load[0]) vld_q[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                if (load[k]) vld_q[k] <= vld_q[k-1];
            end
        end
    end

    generate
        if (STAGES == 1) begin : g_single
            logic [W-1:0] res_q;
            logic         ovf_q;
            logic [W:0]   fin;

            assign fin = finalize(prod_in, rnd_mode, sat_en);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    res_q <= '0;
                    ovf_q <= 1'b0;
                end else if (load[0] && in_valid) begin
                    res_q <= fin[W-1:0];
                    ovf_q <= fin[W];
                end
            end

            assign result   = res_q;
            assign overflow = ovf_q;
        end else begin : g_multi
            // Head slot holds the raw product; scaling happens on the way into slot 1.
            logic signed [PW-1:0] prod_q;
            logic                 rnd_q;
            logic                 sat_q;
            logic [W:0]           head_fin;
            logic [W-1:0]         res_q   [1:STAGES-1];
            logic [STAGES-1:1]    ovf_q;
            logic [W-1:0]         src_res [1:STAGES-1];
            logic [STAGES-1:1]    src_ovf;

            assign head_fin = finalize(prod_q, rnd_q, sat_q);

            for (genvar gi = 1; gi < STAGES; gi++) begin : g_src
                if (gi == 1) begin : g_head
                    assign src_res[gi] = head_fin[W-1:0];
                    assign src_ovf[gi] = head_fin[W];
                end else begin : g_chain
                    assign src_res[gi] = res_q[gi-1];
                    assign src_ovf[gi] = ovf_q[gi-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prod_q <= '0;
                    rnd_q  <= 1'b0;
                    sat_q  <= 1'b0;
                end else if (load[0] && in_valid) begin
                    prod_q <= prod_in;
                    rnd_q  <= rnd_mode;
                    sat_q  <= sat_en;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 1; k < STAGES; k++) begin
                        res_q[k] <= '0;
                        ovf_q[k] <= 1'b0;
                    end
                end else begin
                    for (int k = 1; k < STAGES; k++) begin
                        if (load[k] && vld_q[k-1]) begin
                            res_q[k] <= src_res[k];
                            ovf_q[k] <= src_ovf[k];
                        end
                    end
                end
            end

            assign result   = res_q[STAGES-1];
            assign overflow = ovf_q[STAGES-1];
        end
    endgenerate

endmodule

// File: tb/tb_fixed_mul_pipe.sv
// Directed and streaming checks for fixed_mul_pipe: table vectors, backpressure,
// full-rate parameter sweep and asynchronous reset while transactions are in flight.
module tb_fixed_mul_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        rnd_mode = 1'b0;
    logic        sat_en = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] a = '0;
    logic [15:0] b = '0;

    logic        in_ready, out_valid, overflow;
    logic [15:0] result;
    logic        s1_ir, s1_ov, s1_of;
    logic [15:0] s1_res;
    logic        s4_ir, s4_ov, s4_of;
    logic [15:0] s4_res;
    logic        q4_ir, q4_ov, q4_of;
    logic [15:0] q4_res;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fixed_mul_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .rnd_mode(rnd_mode), .sat_en(sat_en),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .overflow(overflow)
    );
    fixed_mul_pipe #(.STAGES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s1_ir),
        .a(a), .b(b), .rnd_mode(rnd_mode), .sat_en(sat_en),
        .out_valid(s1_ov), .out_ready(out_ready), .result(s1_res), .overflow(s1_of)
    );
    fixed_mul_pipe #(.STAGES(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s4_ir),
        .a(a), .b(b), .rnd_mode(rnd_mode), .sat_en(sat_en),
        .out_valid(s4_ov), .out_ready(out_ready), .result(s4_res), .overflow(s4_of)
    );
    fixed_mul_pipe #(.INT_BITS(4), .FRAC_BITS(12)) u_q4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(q4_ir),
        .a(a), .b(b), .rnd_mode(rnd_mode), .sat_en(sat_en),
        .out_valid(q4_ov), .out_ready(out_ready), .result(q4_res), .overflow(q4_of)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        rnd;
        logic        sat;
        logic [15:0] res;
        logic        ovf;
    } vec_t;

    vec_t        vecs[16];
    logic [15:0] sw_a[6];
    logic [15:0] sw_b[6];
    logic        sw_r[6];
    logic        sw_s[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference: 64-bit integer product, scaled, range-checked against 16-bit signed.
    function automatic logic [16:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic rnd, input logic sat, input int frac);
        longint      p;
        longint      s;
        logic        ovf;
        logic [15:0] r;
        p = longint'($signed(ma)) * longint'($signed(mb));
        if (rnd) p = p + (longint'(1) << (frac - 1));
        s   = p >>> frac;
        ovf = (s > 32767) || (s < -32768);
        if (sat && ovf) r = (s > 0) ? 16'h7FFF : 16'h8000;
        else r = s[15:0];
        return {ovf, r};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int acc;
        bit seen;
        @(negedge clk);
        a = v.a; b = v.b; rnd_mode = v.rnd; sat_en = v.sat;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("vec_in_ready", 32'(in_ready), 32'(1'b1));
        acc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            #1;
            if (out_valid) begin
                seen = 1'b1;
                check("vec_latency", 32'(cyc - acc), 32'd2);
                check("vec_result", 32'(result), 32'(v.res));
                check("vec_overflow", 32'(overflow), 32'(v.ovf));
                $display("vec %0d a=%h b=%h rnd=%0d sat=%0d -> result=%h ovf=%0d",
                         idx, v.a, v.b, v.rnd, v.sat, result, overflow);
            end else begin
                @(negedge clk);
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL vec_timeout idx=%0d actual=no_out_valid expected=out_valid", idx);
        end
    endtask

    task automatic backpressure();
        logic [15:0] pa[8];
        logic [15:0] pb[8];
        logic        pr[8];
        logic        ps[8];
        logic [16:0] expq[$];
        logic [16:0] e;
        int          sent, got, occ;
        logic        stall_prev;
        logic [15:0] res_prev;
        logic        ovf_prev;
        sent = 0; got = 0; occ = 0; stall_prev = 1'b0; res_prev = '0; ovf_prev = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pa[i] = 16'($urandom); pb[i] = 16'($urandom);
            pr[i] = 1'($urandom_range(0, 1)); ps[i] = 1'($urandom_range(0, 1));
        end
        for (int t = 0; t < 200 && got < 8; t++) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (sent < 8);
            if (sent < 8) begin
                a = pa[sent]; b = pb[sent]; rnd_mode = pr[sent]; sat_en = ps[sent];
            end
            #1;
            check("bp_in_ready", 32'(in_ready), 32'((occ < 2) || out_ready));
            if (stall_prev) begin
                check("bp_stall_valid", 32'(out_valid), 32'(1'b1));
                check("bp_stall_result", 32'(result), 32'(res_prev));
                check("bp_stall_ovf", 32'(overflow), 32'(ovf_prev));
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL bp_extra actual=result_%h expected=no_result", result);
                end else begin
                    e = expq.pop_front();
                    check("bp_result", 32'(result), 32'(e[15:0]));
                    check("bp_ovf", 32'(overflow), 32'(e[16]));
                    $display("bp out %0d result=%h ovf=%0d", got, result, overflow);
                    occ--;
                end
                got++;
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(a, b, rnd_mode, sat_en, 8));
                sent++;
                occ++;
            end
            stall_prev = out_valid && !out_ready;
            res_prev   = result;
            ovf_prev   = overflow;
        end
        if (got < 8) begin
            checks++; errors++;
            $display("FAIL bp_timeout actual=%0d expected=8", got);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("bp_drained", 32'(out_valid), 32'(1'b0));
    endtask

    task automatic lane_chk(input string nm, input int t, input int stg, input int frac,
                            input logic ov, input logic [15:0] r, input logic of);
        int          k;
        logic [16:0] e;
        k = t - stg;
        if (k >= 0 && k < 6) begin
            e = model(sw_a[k], sw_b[k], sw_r[k], sw_s[k], frac);
            check({nm, "_valid"}, 32'(ov), 32'(1'b1));
            check({nm, "_result"}, 32'(r), 32'(e[15:0]));
            check({nm, "_ovf"}, 32'(of), 32'(e[16]));
        end else begin
            check({nm, "_idle"}, 32'(ov), 32'(1'b0));
        end
    endtask

    task automatic sweep();
        for (int i = 0; i < 6; i++) begin
            sw_a[i] = 16'($urandom); sw_b[i] = 16'($urandom);
            sw_r[i] = 1'($urandom_range(0, 1)); sw_s[i] = 1'($urandom_range(0, 1));
        end
        sw_a[0] = 16'h1000; sw_b[0] = 16'h0800; sw_r[0] = 1'b0; sw_s[0] = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            in_valid = (t < 6);
            if (t < 6) begin
                a = sw_a[t]; b = sw_b[t]; rnd_mode = sw_r[t]; sat_en = sw_s[t];
            end
            #1;
            lane_chk("sw_s2", t, 2, 8, out_valid, result, overflow);
            lane_chk("sw_s1", t, 1, 8, s1_ov, s1_res, s1_of);
            lane_chk("sw_s4", t, 4, 8, s4_ov, s4_res, s4_of);
            lane_chk("sw_q4", t, 2, 12, q4_ov, q4_res, q4_of);
            $display("sweep cyc %0d s2=%h/%0d s1=%h/%0d s4=%h/%0d q4=%h/%0d", t,
                     result, out_valid, s1_res, s1_ov, s4_res, s4_ov, q4_res, q4_ov);
        end
        in_valid = 1'b0;
    endtask

    task automatic reset_midflight();
        vec_t v;
        do_reset();
        @(negedge clk);
        a = 16'h0180; b = 16'h0200; rnd_mode = 1'b0; sat_en = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        a = 16'h0200; b = 16'h0300;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("rst_pre_valid", 32'(out_valid), 32'(1'b1));
        check("rst_pre_result", 32'(result), 32'h0300);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(out_valid), 32'(1'b0));
        check("rst_async_result", 32'(result), 32'h0);
        check("rst_async_ovf", 32'(overflow), 32'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            #1;
            check("rst_no_ghost", 32'(out_valid), 32'(1'b0));
        end
        v = '{16'h0200, 16'h0300, 1'b0, 1'b0, 16'h0600, 1'b0};
        run_vec(v, 99);
    endtask

    initial begin
        vecs[0]  = '{16'h0180, 16'h0200, 1'b0, 1'b0, 16'h0300, 1'b0};
        vecs[1]  = '{16'h6400, 16'h0200, 1'b0, 1'b0, 16'hC800, 1'b1};
        vecs[2]  = '{16'h6400, 16'h0200, 1'b0, 1'b1, 16'h7FFF, 1'b1};
        vecs[3]  = '{16'h8000, 16'hFF00, 1'b0, 1'b1, 16'h7FFF, 1'b1};
        vecs[4]  = '{16'h8000, 16'hFF00, 1'b0, 1'b0, 16'h8000, 1'b1};
        vecs[5]  = '{16'h0001, 16'h0080, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[6]  = '{16'h0001, 16'h0080, 1'b1, 1'b0, 16'h0001, 1'b0};
        vecs[7]  = '{16'hFFFF, 16'h0080, 1'b0, 1'b0, 16'hFFFF, 1'b0};
        vecs[8]  = '{16'hFFFF, 16'h0080, 1'b1, 1'b0, 16'h0000, 1'b0};
        vecs[9]  = '{16'hFE00, 16'h0180, 1'b0, 1'b0, 16'hFD00, 1'b0};
        vecs[10] = '{16'h8000, 16'h0200, 1'b0, 1'b1, 16'h8000, 1'b1};
        vecs[11] = '{16'h8000, 16'h0200, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[12] = '{16'h0003, 16'h0080, 1'b1, 1'b0, 16'h0002, 1'b0};
        vecs[13] = '{16'h7FFF, 16'h0100, 1'b0, 1'b1, 16'h7FFF, 1'b0};
        vecs[14] = '{16'h8000, 16'h0100, 1'b1, 1'b1, 16'h8000, 1'b0};
        vecs[15] = '{16'h7FFF, 16'h7FFF, 1'b0, 1'b1, 16'h7FFF, 1'b1};

        repeat (2) @(negedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'(1'b0));
        check("reset_result", 32'(result), 32'h0);
        check("reset_overflow", 32'(overflow), 32'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", 32'(in_ready), 32'(1'b1));

        for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

        do_reset();
        backpressure();

        do_reset();
        sweep();

        reset_midflight();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
